// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six T-state sequencer (fetch T1-T3, execute T4-T6)
// that decodes state plus opcode into the datapath control word.
// State advances on the falling clock edge so the control word is stable
// around each rising edge, where the datapath acts. HLT parks the sequencer
// in HALT until reset.
module controller_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instruction,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       CE,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       hlt,
  output logic [2:0] t_state
);

  localparam int unsigned STATE_W = 3;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [STATE_W-1:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6,
    S_BAD  = 3'd7
  } state_e;

  state_e state;
  state_e state_nxt;

  // Next T-state: fixed ring, HLT diverts from T4 into the absorbing HALT.
  always_comb begin
    state_nxt = S_T1;
    case (state)
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = S_T4;
      S_T4:    state_nxt = (instruction == OP_HLT) ? S_HALT : S_T5;
      S_T5:    state_nxt = S_T6;
      S_T6:    state_nxt = S_T1;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_T1;
    endcase
  end

  // State register: falling-edge update, asynchronous return to T1.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= S_T1;
    end else begin
      state <= state_nxt;
    end
  end

  // Control word decode; reset masks the T1 word so all strobes are idle.
  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    Lm  = 1'b1;
    CE  = 1'b1;
    Li  = 1'b1;
    Ei  = 1'b1;
    La  = 1'b1;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    Lb  = 1'b1;
    Lo  = 1'b1;
    hlt = 1'b0;
    if (!rst) begin
      case (state)
        S_T1: begin
          Ep = 1'b1;
          Lm = 1'b0;
        end
        S_T2: begin
          Cp = 1'b1;
        end
        S_T3: begin
          CE = 1'b0;
          Li = 1'b0;
        end
        S_T4: begin
          case (instruction)
            OP_LDA, OP_ADD, OP_SUB: begin
              Ei = 1'b0;
              Lm = 1'b0;
            end
            OP_OUT: begin
              Ea = 1'b1;
              Lo = 1'b0;
            end
            OP_HLT: begin
              hlt = 1'b1;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (instruction)
            OP_LDA: begin
              CE = 1'b0;
              La = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              CE = 1'b0;
              Lb = 1'b0;
            end
            default: ;
          endcase
        end
        S_T6: begin
          case (instruction)
            OP_ADD: begin
              Eu = 1'b1;
              La = 1'b0;
            end
            OP_SUB: begin
              Eu = 1'b1;
              Su = 1'b1;
              La = 1'b0;
            end
            default: ;
          endcase
        end
        S_HALT: begin
          hlt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Debug view of the current T-state.
  assign t_state = STATE_W'(state);

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: per-state control-word table for
// LDA/ADD/SUB/OUT/NOP, then hand sequences for HLT and mid-instruction reset.
`timescale 1ns/1ps
module tb_controller_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] instruction;
  logic       Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt;
  logic [2:0] t_state;

  int n_tests;
  int n_fail;

  // Word bit layout: {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo,hlt}
  localparam logic [12:0] B_CP  = 13'h1000;
  localparam logic [12:0] B_EP  = 13'h0800;
  localparam logic [12:0] B_LM  = 13'h0400;
  localparam logic [12:0] B_CE  = 13'h0200;
  localparam logic [12:0] B_LI  = 13'h0100;
  localparam logic [12:0] B_EI  = 13'h0080;
  localparam logic [12:0] B_LA  = 13'h0040;
  localparam logic [12:0] B_EA  = 13'h0020;
  localparam logic [12:0] B_SU  = 13'h0010;
  localparam logic [12:0] B_EU  = 13'h0008;
  localparam logic [12:0] B_LB  = 13'h0004;
  localparam logic [12:0] B_LO  = 13'h0002;
  localparam logic [12:0] B_HLT = 13'h0001;
  // Inactive word: active-low strobes high, active-high strobes low.
  localparam logic [12:0] INACT = 13'b0_0_1_1_1_1_1_0_0_0_1_1_0;

  typedef struct {
    logic [3:0]  instr;
    logic [2:0]  ts;
    logic [12:0] asserted;  // signals flipped away from the inactive word
  } vec_t;

  vec_t vecs[30];

  controller_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .Cp          (Cp),
    .Ep          (Ep),
    .Lm          (Lm),
    .CE          (CE),
    .Li          (Li),
    .Ei          (Ei),
    .La          (La),
    .Ea          (Ea),
    .Su          (Su),
    .Eu          (Eu),
    .Lb          (Lb),
    .Lo          (Lo),
    .hlt         (hlt),
    .t_state     (t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] word_now();
    return {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt};
  endfunction

  task automatic check_now(input string name, input logic [2:0] ts_exp,
                           input logic [12:0] asserted);
    logic [12:0] exp_word;
    exp_word = INACT ^ asserted;
    n_tests++;
    if (t_state !== ts_exp || word_now() !== exp_word) begin
      n_fail++;
      $display("FAIL %s: t_state=%0d word=%013b, required t_state=%0d word=%013b",
               name, t_state, word_now(), ts_exp, exp_word);
    end
  endtask

  // Drive opcode at the start of a state, check around the rising edge,
  // then move to just after the falling edge that starts the next state.
  task automatic step_check(input string name, input logic [3:0] instr,
                            input logic [2:0] ts_exp, input logic [12:0] asserted);
    instruction = instr;
    @(posedge clk);
    #1;
    check_now(name, ts_exp, asserted);
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // LDA
    vecs[0]  = '{4'b0000, 3'd0, B_EP | B_LM};
    vecs[1]  = '{4'b0000, 3'd1, B_CP};
    vecs[2]  = '{4'b0000, 3'd2, B_CE | B_LI};
    vecs[3]  = '{4'b0000, 3'd3, B_EI | B_LM};
    vecs[4]  = '{4'b0000, 3'd4, B_CE | B_LA};
    vecs[5]  = '{4'b0000, 3'd5, 13'h0};
    // ADD
    vecs[6]  = '{4'b0001, 3'd0, B_EP | B_LM};
    vecs[7]  = '{4'b0001, 3'd1, B_CP};
    vecs[8]  = '{4'b0001, 3'd2, B_CE | B_LI};
    vecs[9]  = '{4'b0001, 3'd3, B_EI | B_LM};
    vecs[10] = '{4'b0001, 3'd4, B_CE | B_LB};
    vecs[11] = '{4'b0001, 3'd5, B_EU | B_LA};
    // SUB
    vecs[12] = '{4'b0010, 3'd0, B_EP | B_LM};
    vecs[13] = '{4'b0010, 3'd1, B_CP};
    vecs[14] = '{4'b0010, 3'd2, B_CE | B_LI};
    vecs[15] = '{4'b0010, 3'd3, B_EI | B_LM};
    vecs[16] = '{4'b0010, 3'd4, B_CE | B_LB};
    vecs[17] = '{4'b0010, 3'd5, B_EU | B_SU | B_LA};
    // OUT
    vecs[18] = '{4'b1110, 3'd0, B_EP | B_LM};
    vecs[19] = '{4'b1110, 3'd1, B_CP};
    vecs[20] = '{4'b1110, 3'd2, B_CE | B_LI};
    vecs[21] = '{4'b1110, 3'd3, B_EA | B_LO};
    vecs[22] = '{4'b1110, 3'd4, 13'h0};
    vecs[23] = '{4'b1110, 3'd5, 13'h0};
    // NOP, with an HLT opcode on the bus during fetch (must be ignored)
    vecs[24] = '{4'b1111, 3'd0, B_EP | B_LM};
    vecs[25] = '{4'b1111, 3'd1, B_CP};
    vecs[26] = '{4'b1111, 3'd2, B_CE | B_LI};
    vecs[27] = '{4'b0011, 3'd3, 13'h0};
    vecs[28] = '{4'b0011, 3'd4, 13'h0};
    vecs[29] = '{4'b0011, 3'd5, 13'h0};

    // Reset asserted mid-clock, held across several edges.
    rst = 1'b0;
    instruction = 4'b0000;
    #2 rst = 1'b1;
    #1 check_now("reset_assert", 3'd0, 13'h0);
    repeat (3) @(posedge clk);
    #1 check_now("reset_hold", 3'd0, 13'h0);

    // Release just after a falling edge: T1 word appears before the rising edge.
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_now("reset_release_t1", 3'd0, B_EP | B_LM);

    for (int i = 0; i < 30; i++) begin
      step_check($sformatf("vec%0d", i), vecs[i].instr, vecs[i].ts, vecs[i].asserted);
    end

    // Back to T1 after the NOP: 6 clocks per instruction.
    step_check("after_nop_t1", 4'b0000, 3'd0, B_EP | B_LM);
    step_check("hlt_t2", 4'b1111, 3'd1, B_CP);
    step_check("hlt_t3", 4'b1111, 3'd2, B_CE | B_LI);
    step_check("hlt_t4", 4'b1111, 3'd3, B_HLT);
    step_check("hlt_enter", 4'b1111, 3'd6, B_HLT);
    repeat (20) @(posedge clk);
    #1 check_now("hlt_stay20", 3'd6, B_HLT);
    instruction = 4'b0001;
    #1 check_now("hlt_opcode_ignored", 3'd6, B_HLT);

    // Reset while halted.
    rst = 1'b1;
    #1 check_now("reset_in_halt", 3'd0, 13'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    step_check("resume_t1", 4'b0001, 3'd0, B_EP | B_LM);
    step_check("resume_t2", 4'b0001, 3'd1, B_CP);
    step_check("resume_t3", 4'b0001, 3'd2, B_CE | B_LI);

    // In T4 an opcode change shows through combinationally.
    instruction = 4'b0001;
    @(posedge clk);
    #1 check_now("t4_add", 3'd3, B_EI | B_LM);
    instruction = 4'b1110;
    #1 check_now("t4_swap_out", 3'd3, B_EA | B_LO);
    instruction = 4'b0001;
    #1 check_now("t4_swap_back", 3'd3, B_EI | B_LM);
    @(negedge clk);
    #1;

    // Reset during ADD T5: abandon immediately, no further strobes.
    @(posedge clk);
    #1 check_now("add_t5", 3'd4, B_CE | B_LB);
    rst = 1'b1;
    #1 check_now("reset_in_t5", 3'd0, 13'h0);
    @(negedge clk);
    #1 check_now("reset_in_t5_held", 3'd0, 13'h0);
    rst = 1'b0;
    #1 check_now("t5_release_t1", 3'd0, B_EP | B_LM);
    step_check("post_rst_t1", 4'b0000, 3'd0, B_EP | B_LM);
    step_check("post_rst_t2", 4'b0000, 3'd1, B_CP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 control unit: a 6-state T-cycle sequencer that consumes the 4-bit opcode produced by the instruction register and drives the control word for every datapath block, including the instruction register's own `Li`/`Ei` strobes. It runs a fixed fetch cycle (T1–T3) and an opcode-dependent execute cycle (T4–T6). It stops permanently on HLT until reset.

## Interface
- No parameters.
- `clk` — in, 1 — system clock. State advances on the **falling** edge; datapath registers load on the rising edge.
- `rst` — in, 1 — asynchronous, active-high reset.
- `instruction` — in, 4 — opcode from the instruction register's upper nibble.
- `Cp` — out, 1 — program counter increment (active high).
- `Ep` — out, 1 — program counter drives bus (active high).
- `Lm` — out, 1 — MAR load (active low).
- `CE` — out, 1 — RAM drives bus (active low).
- `Li` — out, 1 — instruction register load (active low).
- `Ei` — out, 1 — instruction register drives operand nibble onto bus (active low).
- `La` — out, 1 — accumulator load (active low).
- `Ea` — out, 1 — accumulator drives bus (active high).
- `Su` — out, 1 — ALU subtract select (1 = subtract, 0 = add).
- `Eu` — out, 1 — ALU drives bus (active high).
- `Lb` — out, 1 — B register load (active low).
- `Lo` — out, 1 — output register load (active low).
- `hlt` — out, 1 — halt indication (active high).
- `t_state` — out, 3 — current state encoding, for debug.

## Operation
- State encoding: T1=0, T2=1, T3=2, T4=3, T5=4, T6=5, HALT=6.
- Unused code 7 drives an inactive word and goes to T1 on the next falling edge.
- Sequence: T1→T2→…→T6→T1.
- In T4 with opcode HLT, the next state is HALT. HALT is absorbing.
- Inactive word: `Cp=Ep=Ea=Su=Eu=0`, `Lm=CE=Li=Ei=La=Lb=Lo=1`, `hlt=0`.
- Each state asserts only the listed signals; every other output holds its inactive value.
- Fetch states (opcode ignored):
  - T1: `Ep=1`, `Lm=0`.
  - T2: `Cp=1`.
  - T3: `CE=0`, `Li=0`.
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111. All other codes are NOP, with an inactive word in T4–T6.
- T4:
  - LDA/ADD/SUB: `Ei=0`, `Lm=0`.
  - OUT: `Ea=1`, `Lo=0`.
  - HLT: `hlt=1`, rest inactive.
- T5:
  - LDA: `CE=0`, `La=0`.
  - ADD/SUB: `CE=0`, `Lb=0`.
  - Others: inactive.
- T6:
  - ADD: `Eu=1`, `La=0`.
  - SUB: `Eu=1`, `Su=1`, `La=0`.
  - Others: inactive.
- HALT: `hlt=1`, rest inactive, `t_state=6`.
- Outputs are combinational decode of state plus `instruction`. The opcode is read only in T4–T6, after the IR has loaded at the T3 rising edge.
- At most one bus driver (`Ep`, `CE=0`, `Ei=0`, `Ea`, `Eu`) is asserted in any state.

## Timing
- Reset: `rst=1` immediately forces state=T1 and the inactive word on all outputs, regardless of clock (`t_state=0`, `hlt=0`).
- On `rst` deassertion the T1 word appears combinationally, so the first rising edge loads the MAR.
- State register changes only on falling `clk` edges. Each state therefore spans falling edge→falling edge and contains exactly one rising edge, where the datapath acts.
- Every instruction takes exactly 6 clocks, including NOP, LDA, ADD, SUB and OUT.
- HLT: `hlt` rises in T4, the 4th state after fetch start. The state enters HALT at the falling edge ending T4 and stays there indefinitely; `t_state` holds at 6.
- `rst` mid-instruction, at any state including HALT: asynchronous return to T1. The partially executed instruction is abandoned, with no further strobes.
- `instruction` changes in T1–T3 have no effect on outputs.
- `instruction` changes in T4–T6 take effect combinationally; the IR guarantees stability there.

## Test plan
- Reset: assert `rst` mid-clock → all outputs at inactive values, `t_state=0`. Release → `Ep=1`, `Lm=0` before the next rising edge.
- LDA (`instruction=0000`) over 6 clocks → word sequence:
  - T1 `Ep,Lm`; T2 `Cp`; T3 `CE,Li`; T4 `Ei,Lm`; T5 `CE,La`; T6 inactive.
  - Then back to `t_state=0`.
- ADD then SUB (0001, 0010) → T5 `CE=0`, `Lb=0`. T6 `Eu=1`, `La=0`, with `Su=0` for ADD and `Su=1` for SUB.
- OUT (1110) → T4 `Ea=1`, `Lo=0`; T5 and T6 inactive. NOP (0011) → T4–T6 all inactive; cycle still 6 clocks.
- HLT (1111) → `hlt=1` in T4. After 20 further clocks: `t_state=6`, `hlt=1`, no strobes.
- Reset during ADD T5 and again during HALT → immediate `t_state=0`, inactive word, `hlt=0`. Normal fetch resumes after release.
